// File: rtl/i2s_pkg.sv
// Shared I2S definitions for the playback and capture paths.
package i2s_pkg;

  // Word-select encoding on the ws line.
  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

  // Link state: IDLE holds the bus quiet, RUN clocks frames out.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/i2s_tx_fifo.sv
// Synchronous FIFO holding packed {left, right} sample pairs.
// The read data shows the head entry combinationally (first-word fall-through).
module i2s_tx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign level   = level_q;

  // Next pointer and occupancy; push and pop together leave the level unchanged.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Sample storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; an empty level means stale entries are never consumed.
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S master transmitter: FIFO-buffered stereo pairs serialised Philips-style
// (one-bit delay after ws changes), MSB first, sck/ws generated locally.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic                          en,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_W-1:0]             s_left,
  input  logic [DATA_W-1:0]             s_right,
  output logic                          sck,
  output logic                          ws,
  output logic                          sd,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int FRAME_W = 2 * DATA_W;
  localparam int BC_W    = $clog2(FRAME_W);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_e               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [BC_W-1:0]      bc_q, bc_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic                 sck_q, sck_d;
  logic                 ws_q, ws_d;
  logic                 sd_q, sd_d;
  logic                 underrun_q, underrun_d;
  logic [BC_W-1:0]      bc_next;
  logic                 frame_start;
  logic                 fifo_full, fifo_empty;
  logic [FRAME_W-1:0]   fifo_rdata;

  i2s_tx_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (HCLK),
    .rst   (HRESET),
    .push  (s_valid && !fifo_full),
    .pop   (frame_start && !fifo_empty),
    .wdata ({s_left, s_right}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign s_ready  = !fifo_full;
  assign sck      = sck_q;
  assign ws       = ws_q;
  assign sd       = sd_q;
  assign underrun = underrun_q;
  assign bc_next  = bc_q + 1'b1;

  // FSM, divider, slot counter and shifter; ws/sd move only with a falling sck.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bc_d        = bc_q;
    shift_d     = shift_q;
    sck_d       = sck_q;
    ws_d        = ws_q;
    sd_d        = sd_q;
    underrun_d  = 1'b0;
    frame_start = 1'b0;

    case (state_q)
      IDLE: begin
        div_d = '0;
        bc_d  = '0;
        sck_d = 1'b0;
        ws_d  = WS_LEFT;
        sd_d  = 1'b0;             // no previous right LSB after idle
        if (en) begin
          state_d     = RUN;
          frame_start = 1'b1;
        end
      end
      RUN: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d = '0;
          sck_d = ~sck_q;
          if (sck_q) begin        // falling toggle: advance to next slot
            if (bc_q == BC_W'(FRAME_W - 1)) begin
              bc_d = '0;
              ws_d = WS_LEFT;
              if (en) begin
                sd_d        = shift_q[FRAME_W-1];   // delayed right LSB
                frame_start = 1'b1;
              end else begin
                state_d = IDLE;
                sd_d    = 1'b0;
              end
            end else begin
              bc_d    = bc_next;
              ws_d    = (bc_next >= BC_W'(DATA_W)) ? WS_RIGHT : WS_LEFT;
              sd_d    = shift_q[FRAME_W-1];
              shift_d = {shift_q[FRAME_W-2:0], 1'b0};
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A frame start loads the next pair, or silence when nothing is buffered.
    if (frame_start) begin
      if (fifo_empty) begin
        shift_d    = '0;
        underrun_d = 1'b1;
      end else begin
        shift_d = fifo_rdata;
      end
    end
  end

  // Transmitter state registers.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bc_q       <= '0;
      shift_q    <= '0;
      sck_q      <= 1'b0;
      ws_q       <= WS_LEFT;
      sd_q       <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bc_q       <= bc_d;
      shift_q    <= shift_d;
      sck_q      <= sck_d;
      ws_q       <= ws_d;
      sd_q       <= sd_d;
      underrun_q <= underrun_d;
    end
  end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

I2S master transmitter: it accepts stereo PCM sample pairs from the SoC bus side through a valid/ready handshake and buffers them in a small FIFO. It drives SCK, WS and SD as clock and frame master toward an external DAC or amplifier. It is the playback counterpart of the SoC's existing I2S microphone capture path, and sits beside it on the HCLK domain, fed by a bus peripheral or DMA.

## Interface
- `DATA_W`, default 16: bits per channel slot. Frame length is 2*DATA_W SCK periods.
- `CLK_DIV`, default 4: HCLK cycles per SCK half-period. Must be ≥1.
- `FIFO_DEPTH`, default 4: stereo pairs buffered. Must be a power of two, ≥2.
- `HCLK` input, 1 bit: single clock, rising edge.
- `HRESET` input, 1 bit: asynchronous, active-high reset.
- `en` input, 1 bit: transmitter enable.
- `s_valid` input, 1 bit: sample pair offered.
- `s_ready` output, 1 bit: FIFO not full.
- `s_left` input, DATA_W bits: left sample, two's complement.
- `s_right` input, DATA_W bits: right sample, two's complement.
- `sck` output, 1 bit: I2S bit clock.
- `ws` output, 1 bit: word select. 0 = left, 1 = right.
- `sd` output, 1 bit: serial data, MSB first.
- `underrun` output, 1 bit: one-HCLK pulse when a frame starts with the FIFO empty.
- `level` output, $clog2(FIFO_DEPTH)+1 bits: FIFO occupancy.

## Operation
- **Push:** a pair is written when `s_valid && s_ready` on an HCLK edge. `s_ready = (level != FIFO_DEPTH)`, computed combinationally from registered occupancy.
- **States:**
  - IDLE: `sck`=0, `ws`=0, `sd`=0, divider cleared.
  - RUN: IDLE→RUN on `en`=1. RUN→IDLE only at a frame boundary (slot counter wraps) with `en`=0. A frame in progress always completes.
- **Divider:** counts 0..CLK_DIV-1 in RUN; at terminal count `sck` toggles.
- **Slot counter:** `bc` runs 0..2*DATA_W-1. It advances on each `sck` falling toggle and wraps to 0.
- **Frame start:** at entry to RUN and at each wrap to `bc`=0:
  - FIFO non-empty: pop one pair into the shift register.
  - FIFO empty: load zeros and pulse `underrun`.
- **Philips one-bit delay:**
  - `ws`=0 for `bc` 0..DATA_W-1 and 1 for `bc` DATA_W..2*DATA_W-1.
  - `sd` in slot `bc` carries frame bit bc-1, where frame = {L[MSB..0], R[MSB..0]}.
  - Slot 0 carries the previous frame's R LSB. That bit is 0 on the first frame after IDLE.
  - So L MSB appears in slot 1 and R MSB in slot DATA_W+1.
- **Output timing:** `ws` and `sd` change only coincident with a falling `sck` toggle, or on RUN entry. They are stable across each rising edge.
- **Simultaneous push and pop in one cycle:** `level` is unchanged and data order is preserved.
- **Push to full FIFO:** ignored, since `s_ready`=0.
- **`en` toggling mid-frame:** no effect until the frame boundary.
- **Reset mid-frame:** all state clears immediately and the FIFO is emptied.
  - Output values under reset: `sck`=`ws`=`sd`=0, `underrun`=0, `level`=0, `s_ready`=1.

## Timing
- All outputs are registered except `s_ready`.
- SCK period is 2*CLK_DIV HCLK cycles. Frame period is 4*DATA_W*CLK_DIV HCLK cycles.
- On the IDLE→RUN cycle:
  - `bc`=0, `ws`=0, `sd`=0, and the pop happens in that same cycle.
  - First rising `sck` occurs CLK_DIV cycles later.
  - First falling `sck` occurs 2*CLK_DIV cycles later; `bc`=1 and `sd`=L MSB from then on.
- Push-to-FIFO latency is 1 cycle: `level` updates the cycle after the handshake.
- `underrun` asserts in the cycle the empty frame start is taken.

## Structure
- **Package `i2s_pkg`:**
  - Holds the WS encoding constants `WS_LEFT`=0 and `WS_RIGHT`=1.
  - Holds the state enum {IDLE, RUN}.
  - Is shared with the capture block.
- **Sub-module `i2s_tx_fifo`:**
  - Synchronous FIFO, width 2*DATA_W, depth FIFO_DEPTH.
  - Interface: push/pop/full/empty/level, same async active-high reset.
- **Top `i2s_tx`:** divider, slot counter, FSM, shift register and delay bit.

## Test plan
- **Reset values:** assert `HRESET` mid-frame. Outputs go to 0 immediately without waiting for a clock, `s_ready`=1, `level`=0. After release, `sck` stays low while `en`=0.
- **Single frame:** DATA_W=16, CLK_DIV=2, push L=0xA5F0 and R=0x0F0F, then `en`=1.
  - Sample `sd` and `ws` on each `sck` rise. Expect slot 0 = 0/ws0, slots 1..16 = A5F0 MSB-first with ws 0 through slot 15 and 1 at slot 16, slots 17..31 = 0F0F bits 15..1.
  - Next frame slot 0 = R LSB = 1.
  - Frame period is 128 HCLK cycles.
- **Underrun:** `en`=1 with an empty FIFO. Exactly one `underrun` pulse per frame, `sd` is all zeros, and `sck` keeps running.
- **Backpressure:** hold `s_valid`=1 with 6 distinct pairs while idle and FIFO_DEPTH=4. `s_ready` drops after 4 pairs, `level`=4. After `en`=1, the pairs transmit in push order with none lost or duplicated.
- **Simultaneous push and pop:** with `level`=2, push on the frame-start pop cycle. `level` stays 2 and order is preserved.
- **Enable drop mid-frame:** deassert `en` at `bc`=5. The frame completes all 32 slots, then IDLE with `sck`/`ws`/`sd` = 0 and the remaining FIFO contents retained.
